// File: rtl/uart_loop_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_loop_bridge                                           |
// | Description : UART receiver -> FIFO -> UART transmitter. The FIFO is     |
// |               fed either by the receiver (loopback echo) or by a host    |
// |               parallel write port.                                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_loop_bridge #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16,
  localparam int AW             = $clog2(FIFO_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_rx_serial,
  input  logic                 i_loop_en,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_clr_err,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overflow,
  output logic [AW:0]          o_fifo_count,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  output logic                 o_tx_serial
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] c_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          c_STOP_LAST = (STOP_BITS == 2);
  localparam logic          c_PAR_EN    = (PARITY != 0);
  localparam logic          c_PAR_ODD   = (PARITY == 1);
  localparam logic [AW:0]   c_DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- receiver
  logic                 r_rx_meta, r_rx_sync;
  rx_state_t            r_rx_state, w_rx_next;
  logic [CW-1:0]        r_rx_cnt;
  logic [BW-1:0]        r_rx_bit;
  logic                 r_rx_stop;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_rx_ferr_acc;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_cur_perr, r_rx_cur_ferr;
  logic                 r_parity_err, r_frame_err;
  logic                 w_rx_tick, w_rx_perr, w_rx_ferr, w_rx_enter_done;

  assign w_rx_tick       = (r_rx_cnt == c_BIT_LAST);
  // Parity error when the ones count of payload+parity has the wrong sense.
  assign w_rx_perr       = c_PAR_EN && ((^r_rx_shift ^ r_rx_par) != c_PAR_ODD);
  assign w_rx_ferr       = r_rx_ferr_acc | ~r_rx_sync;
  assign w_rx_enter_done = (r_rx_state == RX_STOP) && (w_rx_next == RX_DONE);

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx_serial;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_rx_state <= RX_IDLE;
    else         r_rx_state <= w_rx_next;
  end

  // RX next-state logic; START re-checks the line at mid-bit to reject glitches.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (!r_rx_sync) w_rx_next = RX_START;
      RX_START:  if (r_rx_cnt == c_HALF_LAST) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && (r_rx_bit == c_DATA_LAST))
                   w_rx_next = c_PAR_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_tick && (r_rx_stop == c_STOP_LAST)) w_rx_next = RX_DONE;
      RX_DONE:   w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, sampling, and result/sticky-flag capture.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rx_cnt      <= '0;
      r_rx_bit      <= '0;
      r_rx_stop     <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_par      <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
      r_rx_data     <= '0;
      r_rx_cur_perr <= 1'b0;
      r_rx_cur_ferr <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if ((r_rx_state == RX_IDLE) || (r_rx_state != w_rx_next) || w_rx_tick) r_rx_cnt <= '0;
      else                                                                    r_rx_cnt <= r_rx_cnt + CW'(1);
      if (r_rx_state == RX_START) begin
        r_rx_bit      <= '0;
        r_rx_stop     <= 1'b0;
        r_rx_ferr_acc <= 1'b0;
      end
      if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
        r_rx_bit   <= r_rx_bit + BW'(1);
      end
      if ((r_rx_state == RX_PARITY) && w_rx_tick) r_rx_par <= r_rx_sync;
      if ((r_rx_state == RX_STOP) && w_rx_tick) begin
        r_rx_stop     <= 1'b1;
        r_rx_ferr_acc <= w_rx_ferr;
      end
      if (w_rx_enter_done) begin
        r_rx_data     <= r_rx_shift;
        r_rx_cur_perr <= w_rx_perr;
        r_rx_cur_ferr <= w_rx_ferr;
      end
      // A new error outranks a coincident clear.
      r_parity_err <= (w_rx_enter_done & w_rx_perr) | (r_parity_err & ~i_clr_err);
      r_frame_err  <= (w_rx_enter_done & w_rx_ferr) | (r_frame_err & ~i_clr_err);
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic                 w_push, w_pop, w_full, w_wr_en;
  logic [DATA_BITS-1:0] w_push_data;
  tx_state_t            r_tx_state, w_tx_next;

  assign w_full      = (r_count == c_DEPTH);
  assign w_push      = i_loop_en ? ((r_rx_state == RX_DONE) && !r_rx_cur_perr && !r_rx_cur_ferr)
                                 : i_tx_dv;
  assign w_push_data = i_loop_en ? r_rx_data : i_tx_data;
  assign w_pop       = (r_tx_state == TX_IDLE) && (r_count != '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign w_wr_en     = w_push && (!w_full || w_pop);

  // FIFO storage; no reset needed, occupancy guards every read.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - (AW+1)'(1);
      r_overflow <= (w_push & ~w_wr_en) | (r_overflow & ~i_clr_err);
    end
  end

  // ------------------------------------------------------------- transmitter
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic                 r_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_done;
  logic                 w_tx_tick, w_tx_serial;

  assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);

  // TX state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_next;
  end

  // TX next-state logic and line level decode.
  always_comb begin
    w_tx_next   = r_tx_state;
    w_tx_serial = 1'b1;
    case (r_tx_state)
      TX_IDLE:   if (w_pop) w_tx_next = TX_START;
      TX_START: begin
        w_tx_serial = 1'b0;
        if (w_tx_tick) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_serial = r_tx_shift[0];
        if (w_tx_tick && (r_tx_bit == c_DATA_LAST)) w_tx_next = c_PAR_EN ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        w_tx_serial = r_tx_par;
        if (w_tx_tick) w_tx_next = TX_STOP;
      end
      TX_STOP:   if (w_tx_tick && (r_tx_stop == c_STOP_LAST)) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: latch popped entry, shift out bits, flag end of frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      if ((r_tx_state == TX_IDLE) || (r_tx_state != w_tx_next) || w_tx_tick) r_tx_cnt <= '0;
      else                                                                    r_tx_cnt <= r_tx_cnt + CW'(1);
      if (w_pop) begin
        r_tx_shift <= r_mem[r_rd_ptr];
        r_tx_par   <= (^r_mem[r_rd_ptr]) ^ c_PAR_ODD;
        r_tx_bit   <= '0;
        r_tx_stop  <= 1'b0;
      end
      if ((r_tx_state == TX_DATA) && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + BW'(1);
      end
      if ((r_tx_state == TX_STOP) && w_tx_tick) r_tx_stop <= 1'b1;
      r_tx_done <= (r_tx_state == TX_STOP) && (w_tx_next == TX_IDLE);
    end
  end

  assign o_rx_dv      = (r_rx_state == RX_DONE);
  assign o_rx_data    = r_rx_data;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;
  assign o_tx_active  = (r_tx_state != TX_IDLE);
  assign o_tx_done    = r_tx_done;
  assign o_tx_serial  = w_tx_serial;

endmodule
`default_nettype wire

// File: tb/tb_uart_loop_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_loop_bridge                                        |
// | Description : Directed bench for uart_loop_bridge, 7E2, 16 clk/bit,     |
// |               4-entry FIFO.                                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_loop_bridge;
  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;
  localparam int TMO   = 3 * FRAME;

  logic       clk = 1'b0, rstn = 1'b0, rx = 1'b1, loop_en = 1'b1, tx_dv = 1'b0, clr = 1'b0;
  logic [6:0] tx_data = '0;
  logic       rx_dv, perr, ferr, ovf, tx_active, tx_done, tx_serial;
  logic [6:0] rx_data;
  logic [2:0] fifo_count;

  int checks = 0, errors = 0, cyc = 0;

  uart_loop_bridge #(
    .CLOCK_FREQUENCY(160_000), .BAUD_RATE(10_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_serial(rx), .i_loop_en(loop_en),
    .i_tx_dv(tx_dv), .i_tx_data(tx_data), .i_clr_err(clr),
    .o_rx_dv(rx_dv), .o_rx_data(rx_data), .o_parity_err(perr), .o_frame_err(ferr),
    .o_overflow(ovf), .o_fifo_count(fifo_count), .o_tx_active(tx_active),
    .o_tx_done(tx_done), .o_tx_serial(tx_serial)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one 7E2 frame on the rx line, bit 0 (start) first.
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop_low);
    logic [10:0] bits;
    bits = {1'b1, ~stop_low, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_dv(output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (rx_dv !== 1'b1 && n < TMO);
    t = cyc;
    check("rx_dv_seen", rx_dv, 1'b1);
  endtask

  // Capture one frame from tx_serial at mid-bit and check done/active timing.
  task automatic capture_tx(input logic [6:0] d, output int fall);
    logic [10:0] exp_bits, got;
    int n;
    exp_bits = {2'b11, ^d, d, 1'b0};
    got = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_serial !== 1'b0 && n < TMO);
    fall = cyc;
    if (tx_serial !== 1'b0) begin
      check("tx_start_timeout", tx_serial, 1'b0);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      got[i] = tx_serial;
      if (i < 10) repeat (CPB) @(negedge clk);
    end
    check("tx_frame_bits", got, exp_bits);
    while (cyc < fall + FRAME - 1) @(negedge clk);
    check("tx_last_stop_active", {tx_active, tx_done}, 2'b10);
    @(negedge clk);
    check("tx_done_pulse", {tx_done, tx_active}, 2'b10);
  endtask

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       flip;
    logic       stop_low;
    logic       loop;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_echo;
  } vec_t;

  vec_t vec [6];

  initial begin
    int t, fall, n;
    //          data   par flip stopL loop perr ferr echo
    vec[0] = '{7'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[1] = '{7'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[2] = '{7'h2A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[3] = '{7'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[4] = '{7'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[5] = '{7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_serial", tx_serial, 1'b1);
    check("reset_flags", {rx_dv, perr, ferr, ovf, tx_active, tx_done}, 6'b0);
    check("reset_rx_data", rx_data, 7'h00);
    check("reset_count", fifo_count, 3'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Short low glitch must be rejected silently.
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    n = 0;
    repeat (3 * CPB) begin @(negedge clk); if (rx_dv === 1'b1) n++; end
    check("glitch_no_dv", n, 0);
    check("glitch_no_flags", {perr, ferr}, 2'b00);

    // Table-driven receive / echo vectors.
    for (int v = 0; v < 6; v++) begin
      loop_en = vec[v].loop;
      fork
        send_frame(vec[v].data, vec[v].par ^ vec[v].flip, vec[v].stop_low);
        begin
          wait_dv(t);
          check("rx_data", rx_data, vec[v].data);
          check("parity_err", perr, vec[v].exp_perr);
          check("frame_err", ferr, vec[v].exp_ferr);
          @(negedge clk);
          check("count_after_dv", fifo_count, {2'b00, vec[v].exp_echo});
          if (vec[v].exp_echo) begin
            capture_tx(vec[v].data, fall);
            check("tx_fall_latency", fall - t, 2);
          end else begin
            repeat (20) @(negedge clk);
            check("no_echo_idle", {tx_active, tx_serial, fifo_count}, 5'b01000);
          end
        end
      join
      repeat (CPB) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("flags_cleared", {perr, ferr, ovf}, 3'b000);
    end

    // Host mode: six writes on consecutive cycles; the first is popped at once,
    // so 0x01..0x05 fit and the sixth write finds the FIFO full.
    loop_en = 1'b0;
    fork
      begin
        tx_dv = 1'b1;
        for (int k = 1; k <= 5; k++) begin
          tx_data = 7'(k);
          @(negedge clk);
        end
        check("host_count_full", fifo_count, 3'd4);
        tx_data = 7'h06;
        @(negedge clk);
        tx_dv = 1'b0;
        check("host_overflow", ovf, 1'b1);
        check("host_count_after_drop", fifo_count, 3'd4);
      end
      begin
        int f, p;
        p = 0;
        for (int k = 1; k <= 5; k++) begin
          capture_tx(7'(k), f);
          if (k > 1) check("back_to_back_gap", f - p, FRAME + 1);
          p = f;
        end
      end
    join
    repeat (20) @(negedge clk);
    check("host_drained", {tx_active, fifo_count}, 4'b0000);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("overflow_cleared", ovf, 1'b0);

    // Asynchronous reset in the middle of the data bits.
    tx_dv = 1'b1;
    tx_data = 7'h33;
    @(negedge clk);
    tx_data = 7'h44;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("pre_reset_busy", {tx_active, fifo_count}, 4'b1001);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_line", {tx_serial, tx_active}, 2'b10);
    check("async_reset_count", fifo_count, 3'd0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    repeat (4 * CPB) begin @(negedge clk); if (tx_serial !== 1'b1 || tx_active !== 1'b0) n++; end
    check("idle_after_reset", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
